// File: rtl/mc_pkg.sv
// Shared types and bit-index constants for the memory-control datapath.
package mc_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam int T1_IDX = 1;
  localparam int T3_IDX = 3;
  localparam int T4_IDX = 4;
  localparam int T6_IDX = 6;

  localparam int D0_IDX = 0;
  localparam int D1_IDX = 1;
  localparam int D2_IDX = 2;
  localparam int D3_IDX = 3;
  localparam int D5_IDX = 5;
  localparam int D6_IDX = 6;
  localparam int D7_IDX = 7;
endpackage

// File: rtl/ram_req_decode.sv
// Combinational decode of memory read/write requests from timing and opcode.
module ram_req_decode
  import mc_pkg::*;
#(
  parameter bit INT_EN = 1'b1
) (
  input  logic [7:0] T,
  input  logic [7:0] D,
  input  logic       I,
  input  logic       R,
  output logic       rd_req,
  output logic       wr_req
);
  always_comb begin
    wr_req = (D[D3_IDX] & T[T4_IDX]) | (D[D5_IDX] & T[T4_IDX]) |
             (D[D6_IDX] & T[T6_IDX]) | (INT_EN & R & T[T1_IDX]);
    rd_req = (~R & T[T1_IDX]) | (~D[D7_IDX] & I & T[T3_IDX]) |
             (D[D6_IDX] & T[T4_IDX]) |
             ((D[D0_IDX] | D[D1_IDX] | D[D2_IDX]) & T[T4_IDX]);
  end
endmodule

// File: rtl/ram_access_ctrl.sv
// RAM access sequencer: runs each decoded request with wait states and
// freezes the sequence counter via hold until the access completes.
module ram_access_ctrl
  import mc_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_STATES = 1,
  parameter bit INT_EN      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        T,
  input  logic [7:0]        D,
  input  logic              I,
  input  logic              R,
  input  logic [ADDR_W-1:0] ar,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              hold,
  output logic              addr_err,
  output logic              conflict
);
  state_t     state;
  op_t        op;
  logic [2:0] cnt;
  logic       oob;
  logic       rd_req, wr_req, req, oob_now;

  ram_req_decode #(.INT_EN(INT_EN)) u_dec (
    .T(T), .D(D), .I(I), .R(R), .rd_req(rd_req), .wr_req(wr_req)
  );

  assign req     = rd_req | wr_req;
  assign oob_now = {1'b0, ar} >= (ADDR_W+1)'(MEM_DEPTH);
  // Gated by rst so the counter is released the instant reset asserts.
  assign hold    = ~rst & (((state == IDLE) & req) | (state == ACCESS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op          <= OP_RD;
      cnt         <= '0;
      oob         <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      conflict    <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: if (req) begin
          mem_addr  <= ar;
          mem_wdata <= wdata;
          op        <= wr_req ? OP_WR : OP_RD;
          oob       <= oob_now;
          cnt       <= 3'(WAIT_STATES);
          mem_we    <= wr_req & ~oob_now;
          mem_re    <= ~wr_req & ~oob_now;
          state     <= ACCESS;
          if (oob_now)          addr_err <= 1'b1;
          if (rd_req && wr_req) conflict <= 1'b1;
        end
        ACCESS: if (cnt != 3'd0) begin
          cnt <= cnt - 3'd1;
        end else begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          // Out-of-range reads still complete so the sequencer never stalls.
          if (op == OP_RD) begin
            rdata_valid <= 1'b1;
            if (!oob) rdata <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized transaction-level check of three differently parameterized instances.
module tb_ram_access_ctrl;
  localparam int NDUT = 3;
  localparam int WS[NDUT]    = '{1, 0, 7};
  localparam int DEPTH[NDUT] = '{4096, 2048, 3000};
  localparam bit INTEN[NDUT] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  t_s[NDUT], d_s[NDUT];
  logic        i_s[NDUT], r_s[NDUT];
  logic [11:0] ar_s[NDUT];
  logic [15:0] wd_s[NDUT], mrd_s[NDUT];
  logic [11:0] addr_o[NDUT];
  logic [15:0] wdat_o[NDUT], rdat_o[NDUT];
  logic        we_o[NDUT], re_o[NDUT], rv_o[NDUT], hold_o[NDUT], err_o[NDUT], conf_o[NDUT];

  // reference state
  logic [15:0] m_rdata[NDUT];
  bit          m_err[NDUT], m_conf[NDUT];

  int checks = 0;
  int errors = 0;

  ram_access_ctrl #(.WAIT_STATES(WS[0]), .MEM_DEPTH(DEPTH[0]), .INT_EN(INTEN[0])) dut0 (
    .clk(clk), .rst(rst), .T(t_s[0]), .D(d_s[0]), .I(i_s[0]), .R(r_s[0]), .ar(ar_s[0]),
    .wdata(wd_s[0]), .mem_rdata(mrd_s[0]), .mem_addr(addr_o[0]), .mem_wdata(wdat_o[0]),
    .mem_we(we_o[0]), .mem_re(re_o[0]), .rdata(rdat_o[0]), .rdata_valid(rv_o[0]),
    .hold(hold_o[0]), .addr_err(err_o[0]), .conflict(conf_o[0]));
  ram_access_ctrl #(.WAIT_STATES(WS[1]), .MEM_DEPTH(DEPTH[1]), .INT_EN(INTEN[1])) dut1 (
    .clk(clk), .rst(rst), .T(t_s[1]), .D(d_s[1]), .I(i_s[1]), .R(r_s[1]), .ar(ar_s[1]),
    .wdata(wd_s[1]), .mem_rdata(mrd_s[1]), .mem_addr(addr_o[1]), .mem_wdata(wdat_o[1]),
    .mem_we(we_o[1]), .mem_re(re_o[1]), .rdata(rdat_o[1]), .rdata_valid(rv_o[1]),
    .hold(hold_o[1]), .addr_err(err_o[1]), .conflict(conf_o[1]));
  ram_access_ctrl #(.WAIT_STATES(WS[2]), .MEM_DEPTH(DEPTH[2]), .INT_EN(INTEN[2])) dut2 (
    .clk(clk), .rst(rst), .T(t_s[2]), .D(d_s[2]), .I(i_s[2]), .R(r_s[2]), .ar(ar_s[2]),
    .wdata(wd_s[2]), .mem_rdata(mrd_s[2]), .mem_addr(addr_o[2]), .mem_wdata(wdat_o[2]),
    .mem_we(we_o[2]), .mem_re(re_o[2]), .rdata(rdat_o[2]), .rdata_valid(rv_o[2]),
    .hold(hold_o[2]), .addr_err(err_o[2]), .conflict(conf_o[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs(input int k);
    t_s[k] = '0; d_s[k] = '0; i_s[k] = 1'b0; r_s[k] = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_rdata[k] = '0; m_err[k] = 1'b0; m_conf[k] = 1'b0;
    end
  endtask

  // One T step on instance k, checked cycle by cycle against the request rules.
  task automatic run_txn(input int k, input logic [7:0] t, input logic [7:0] d,
                         input logic i, input logic r, input logic [11:0] a,
                         input logic [15:0] wd, input logic [15:0] mrd);
    bit wr, rd, inr, strobe;
    int ws;
    wr  = (d[3] && t[4]) || (d[5] && t[4]) || (d[6] && t[6]) || (INTEN[k] && r && t[1]);
    rd  = (!r && t[1]) || (!d[7] && i && t[3]) || (d[6] && t[4]) ||
          ((d[0] || d[1] || d[2]) && t[4]);
    ws  = WS[k];
    inr = int'(a) < DEPTH[k];
    @(negedge clk);
    t_s[k] = t; d_s[k] = d; i_s[k] = i; r_s[k] = r; ar_s[k] = a; wd_s[k] = wd; mrd_s[k] = mrd;
    #1;
    if (!(wr || rd)) begin
      for (int c = 0; c < 3; c++) begin
        if (c > 0) begin @(negedge clk); #1; end
        chk("idle_hold", 32'(hold_o[k]), 0);
        chk("idle_we", 32'(we_o[k]), 0);
        chk("idle_re", 32'(re_o[k]), 0);
        chk("idle_rv", 32'(rv_o[k]), 0);
      end
      clear_inputs(k);
      return;
    end
    if (wr && rd) m_conf[k] = 1'b1;
    if (!inr)     m_err[k]  = 1'b1;
    for (int c = 0; c <= ws + 2; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      strobe = inr && c >= 1 && c <= ws + 1;
      chk("hold", 32'(hold_o[k]), 32'(c <= ws + 1));
      chk("we", 32'(we_o[k]), 32'(strobe && wr));
      chk("re", 32'(re_o[k]), 32'(strobe && !wr));
      chk("rv_early", 32'(rv_o[k]), 0);
      if (c >= 1) begin
        chk("addr", 32'(addr_o[k]), 32'(a));
        chk("wdata", 32'(wdat_o[k]), 32'(wd));
        chk("addr_err", 32'(err_o[k]), 32'(m_err[k]));
        chk("conflict", 32'(conf_o[k]), 32'(m_conf[k]));
      end
    end
    @(negedge clk);
    clear_inputs(k);
    #1;
    if (!wr && inr) m_rdata[k] = mrd;
    chk("rvalid", 32'(rv_o[k]), 32'(!wr));
    chk("rdata", 32'(rdat_o[k]), 32'(m_rdata[k]));
    chk("hold_rel", 32'(hold_o[k]), 0);
    @(negedge clk); #1;
    chk("rv_pulse", 32'(rv_o[k]), 0);
    chk("rdata_hold", 32'(rdat_o[k]), 32'(m_rdata[k]));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t, d;
    int k;
    for (int j = 0; j < NDUT; j++) begin
      clear_inputs(j); ar_s[j] = '0; wd_s[j] = '0; mrd_s[j] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    for (int j = 0; j < NDUT; j++) begin
      chk("rst_hold", 32'(hold_o[j]), 0);
      chk("rst_we", 32'(we_o[j]), 0);
      chk("rst_err", 32'(err_o[j]), 0);
    end
    rst = 1'b0;

    // directed
    run_txn(0, 8'h10, 8'h08, 0, 0, 12'h123, 16'hBEEF, 16'h0000);  // D3 T4 write
    run_txn(0, 8'h10, 8'h04, 0, 0, 12'h456, 16'h1111, 16'h5A5A);  // D2 T4 read
    run_txn(1, 8'h02, 8'h00, 0, 0, 12'h010, 16'h2222, 16'hA5A5);  // T1 read, 0 waits
    run_txn(2, 8'h02, 8'h00, 0, 0, 12'h020, 16'h3333, 16'hC3C3);  // T1 read, 7 waits
    run_txn(1, 8'h10, 8'h20, 0, 0, 12'h900, 16'h4444, 16'h0000);  // out-of-range write
    run_txn(1, 8'h02, 8'h00, 0, 0, 12'h901, 16'h0, 16'h7777);     // out-of-range read
    run_txn(0, 8'h10, 8'h48, 0, 0, 12'h055, 16'h5555, 16'h0000);  // D6|D3 conflict
    run_txn(1, 8'h02, 8'h00, 0, 1, 12'h066, 16'h6666, 16'h0000);  // R&T1, INT_EN=0
    run_txn(2, 8'h02, 8'h00, 0, 1, 12'h077, 16'h7777, 16'h0000);  // R&T1, INT_EN=1
    run_txn(0, 8'h00, 8'h08, 1, 1, 12'h088, 16'h8888, 16'h0000);  // zero T

    // randomized
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, NDUT - 1);
      t = ($urandom_range(0, 8) == 8) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      d = 8'(1 << $urandom_range(0, 7));
      run_txn(k, t, d, 1'($urandom), 1'($urandom), 12'($urandom), 16'($urandom), 16'($urandom));
    end

    // asynchronous reset in the second access cycle of a write
    @(negedge clk);
    t_s[0] = 8'h10; d_s[0] = 8'h08; ar_s[0] = 12'h3C3; wd_s[0] = 16'hCAFE;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_we", 32'(we_o[0]), 1);
    chk("pre_rst_hold", 32'(hold_o[0]), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_we", 32'(we_o[0]), 0);
    chk("rst_async_hold", 32'(hold_o[0]), 0);
    model_reset();
    @(negedge clk);
    clear_inputs(0);
    rst = 1'b0;
    #1;
    for (int j = 0; j < NDUT; j++) begin
      chk("post_addr", 32'(addr_o[j]), 0);
      chk("post_wdata", 32'(wdat_o[j]), 0);
      chk("post_rdata", 32'(rdat_o[j]), 0);
      chk("post_err", 32'(err_o[j]), 0);
      chk("post_conf", 32'(conf_o[j]), 0);
      chk("post_rv", 32'(rv_o[j]), 0);
      chk("post_re", 32'(re_o[j]), 0);
    end
    run_txn(0, 8'h10, 8'h02, 0, 0, 12'h0AB, 16'h0, 16'h1234);  // IDLE after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
